// File: rtl/chunk_line_serializer_pkg.sv
// Shared types and constants for the chunk line serializer.
// Holds the FSM state enum, default chunk geometry and line-level constants.
package chunk_line_serializer_pkg;

    localparam int unsigned DEFAULT_CHUNK_W    = 6;
    localparam int unsigned DEFAULT_TAG_W      = 2;
    localparam int unsigned DEFAULT_NUM_CHUNKS = 4;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    // start + tag + data + parity + stop
    localparam int unsigned SYMBOL_BITS = 1 + DEFAULT_TAG_W + DEFAULT_CHUNK_W + 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        TAG,
        DATA,
        PARITY,
        STOP
    } state_e;

    // Bits needed for a counter running 0..max_count-1 (never narrower than 1).
    function automatic int unsigned counter_width(input int unsigned max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/chunk_line_serializer_bit_period_timer.sv
// Baud counter: emits a one-cycle bit_tick every BIT_PERIOD cycles while running.
// A restart pulse realigns the count so the next bit lasts a full period.
module bit_period_timer
    import chunk_line_serializer_pkg::*;
#(
    parameter int unsigned BIT_PERIOD = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic run,
    output logic bit_tick
);

    localparam int unsigned CNT_W = counter_width(BIT_PERIOD);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_PERIOD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick = run && (cnt_q == LAST);

endmodule

// File: rtl/chunk_line_serializer.sv
// Serializes one compressed word (four tagged chunks) as four framed symbols on tx_bit.
// Each symbol: start, tag LSB-first, data LSB-first, even parity, stop.
module chunk_line_serializer
    import chunk_line_serializer_pkg::*;
#(
    parameter int unsigned CHUNK_W    = DEFAULT_CHUNK_W,
    parameter int unsigned TAG_W      = DEFAULT_TAG_W,
    parameter int unsigned NUM_CHUNKS = DEFAULT_NUM_CHUNKS,
    parameter int unsigned BIT_PERIOD = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CHUNK_W-1:0] c1,
    input  logic [CHUNK_W-1:0] c2,
    input  logic [CHUNK_W-1:0] c3,
    input  logic [CHUNK_W-1:0] c4,
    input  logic [TAG_W-1:0]   e1,
    input  logic [TAG_W-1:0]   e2,
    input  logic [TAG_W-1:0]   e3,
    input  logic [TAG_W-1:0]   e4,
    output logic               tx_bit,
    output logic               tx_active,
    output logic [1:0]         chunk_idx,
    output logic               frame_done
);

    localparam int unsigned MAX_FIELD = (TAG_W > CHUNK_W) ? TAG_W : CHUNK_W;
    localparam int unsigned BIT_CNT_W = counter_width(MAX_FIELD);

    state_e               state_q, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [1:0]           chunk_q, chunk_d;
    logic                 tx_bit_q, tx_bit_d;
    logic                 tx_active_q;
    logic                 done_q, done_d;
    logic                 accept;
    logic                 bit_tick;

    logic [CHUNK_W-1:0] data_in [NUM_CHUNKS];
    logic [TAG_W-1:0]   tag_in  [NUM_CHUNKS];
    logic [CHUNK_W-1:0] data_q  [NUM_CHUNKS];
    logic [TAG_W-1:0]   tag_q   [NUM_CHUNKS];

    assign data_in[0] = c1;
    assign data_in[1] = c2;
    assign data_in[2] = c3;
    assign data_in[3] = c4;
    assign tag_in[0]  = e1;
    assign tag_in[1]  = e2;
    assign tag_in[2]  = e3;
    assign tag_in[3]  = e4;

    assign in_ready = (state_q == IDLE) && !reset;
    assign accept   = in_valid && in_ready;

    bit_period_timer #(
        .BIT_PERIOD(BIT_PERIOD)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .restart (accept),
        .run     (state_q != IDLE),
        .bit_tick(bit_tick)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        chunk_d   = chunk_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = START;
                    bit_cnt_d = '0;
                    chunk_d   = '0;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_d   = TAG;
                    bit_cnt_d = '0;
                end
            end
            TAG: begin
                if (bit_tick) begin
                    if (bit_cnt_q == BIT_CNT_W'(TAG_W - 1)) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_cnt_q == BIT_CNT_W'(CHUNK_W - 1)) begin
                        state_d   = PARITY;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    bit_cnt_d = '0;
                    if (chunk_q == 2'(NUM_CHUNKS - 1)) begin
                        state_d = IDLE;
                        chunk_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = START;
                        chunk_d = chunk_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line level for the upcoming cycle, so tx_bit stays aligned with state_q.
    logic [CHUNK_W-1:0] cur_data, data_shift;
    logic [TAG_W-1:0]   cur_tag, tag_shift;

    always_comb begin
        cur_data   = data_q[chunk_d];
        cur_tag    = tag_q[chunk_d];
        data_shift = cur_data >> bit_cnt_d;
        tag_shift  = cur_tag >> bit_cnt_d;
        tx_bit_d   = IDLE_LEVEL;
        unique case (state_d)
            START:   tx_bit_d = START_BIT;
            TAG:     tx_bit_d = tag_shift[0];
            DATA:    tx_bit_d = data_shift[0];
            PARITY:  tx_bit_d = ^{cur_tag, cur_data};
            STOP:    tx_bit_d = STOP_BIT;
            default: tx_bit_d = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            chunk_q     <= '0;
            tx_bit_q    <= IDLE_LEVEL;
            tx_active_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            chunk_q     <= chunk_d;
            tx_bit_q    <= tx_bit_d;
            tx_active_q <= (state_d != IDLE);
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < NUM_CHUNKS; i++) begin
                data_q[i] <= data_in[i];
                tag_q[i]  <= tag_in[i];
            end
        end
    end

    assign tx_bit     = tx_bit_q;
    assign tx_active  = tx_active_q;
    assign chunk_idx  = chunk_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_chunk_line_serializer.sv
// Bench for chunk_line_serializer: two instances (BIT_PERIOD 4 and 1) checked each cycle
// against a frame-offset model, plus hand-computed literal expectations.
module tb_chunk_line_serializer;

    typedef struct packed {
        logic [3:0][5:0] c;
        logic [3:0][1:0] e;
    } word_t;

    typedef struct packed {
        logic       tx;
        logic       active;
        logic [1:0] idx;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       checking = 1'b0;
    logic       valid [2];
    word_t      w_in  [2];
    logic       ready [2];
    logic       tx    [2];
    logic       act   [2];
    logic [1:0] idx   [2];
    logic       done  [2];

    logic  m_on [2] = '{1'b0, 1'b0};
    int    m_k  [2] = '{0, 0};
    word_t m_w  [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Expected outputs k cycles after the accepting edge (k==0 is the first start-bit cycle).
    function automatic exp_t model_out(input int bp, input logic on, input int k, input word_t w);
        exp_t        r;
        logic [10:0] sym;
        int          s;
        int          b;
        r = '{tx: 1'b1, active: 1'b0, idx: 2'd0, done: 1'b0};
        if (on && k < 44 * bp) begin
            s        = k / (11 * bp);
            b        = (k / bp) % 11;
            sym      = {1'b1, ^{w.e[s], w.c[s]}, w.c[s], w.e[s], 1'b0};
            r.tx     = sym[b];
            r.active = 1'b1;
            r.idx    = 2'(s);
        end else if (on && k == 44 * bp) begin
            r.done = 1'b1;
        end
        return r;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int BP = (g == 0) ? 4 : 1;

        chunk_line_serializer #(
            .BIT_PERIOD(BP)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (valid[g]),
            .in_ready  (ready[g]),
            .c1        (w_in[g].c[0]),
            .c2        (w_in[g].c[1]),
            .c3        (w_in[g].c[2]),
            .c4        (w_in[g].c[3]),
            .e1        (w_in[g].e[0]),
            .e2        (w_in[g].e[1]),
            .e3        (w_in[g].e[2]),
            .e4        (w_in[g].e[3]),
            .tx_bit    (tx[g]),
            .tx_active (act[g]),
            .chunk_idx (idx[g]),
            .frame_done(done[g])
        );

        always @(posedge clk) begin
            if (reset) begin
                m_on[g] <= 1'b0;
            end else if (valid[g] && !(m_on[g] && m_k[g] < 44 * BP)) begin
                m_on[g] <= 1'b1;
                m_k[g]  <= 0;
                m_w[g]  <= w_in[g];
            end else if (m_on[g]) begin
                if (m_k[g] >= 44 * BP) m_on[g] <= 1'b0;
                else m_k[g] <= m_k[g] + 1;
            end
        end

        always @(negedge clk) begin
            exp_t e;
            if (checking) begin
                e = model_out(BP, m_on[g], m_k[g], m_w[g]);
                check($sformatf("dut%0d tx_bit", g), 32'(tx[g]), 32'(e.tx));
                check($sformatf("dut%0d tx_active", g), 32'(act[g]), 32'(e.active));
                check($sformatf("dut%0d chunk_idx", g), 32'(idx[g]), 32'(e.idx));
                check($sformatf("dut%0d frame_done", g), 32'(done[g]), 32'(e.done));
                check($sformatf("dut%0d in_ready", g), 32'(ready[g]), 32'(!reset && !e.active));
            end
        end
    end

    // Observations on the BIT_PERIOD=4 instance used by the literal checks.
    int   low_run = 0;
    int   low_runs [$];
    int   done_cnt = 0;
    logic prev_done = 1'b0;
    logic [1:0] after_done [$];

    always @(negedge clk) begin
        if (checking) begin
            if (!ready[0]) begin
                low_run <= low_run + 1;
            end else if (low_run != 0) begin
                low_runs.push_back(low_run);
                low_run <= 0;
            end
            if (done[0]) done_cnt <= done_cnt + 1;
            if (prev_done) after_done.push_back({tx[0], act[0]});
            prev_done <= done[0];
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((m_on[0] || m_on[1]) && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) check("idle timeout", 32'd1, 32'd0);
    endtask

    task automatic send(input int g, input word_t w);
        w_in[g]  = w;
        valid[g] = 1'b1;
        tick();
        valid[g] = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        word_t      wa, wb, w3;
        logic [10:0] bits;
        int         active_cnt, done_at, done_seen, base, dbase, abase;

        reset    = 1'b1;
        valid[0] = 1'b0;
        valid[1] = 1'b0;
        w_in[0]  = '0;
        w_in[1]  = '0;

        // 1. reset idle
        tick();
        checking = 1'b1;
        @(negedge clk);
        check("reset in_ready", 32'(ready[0]), 32'd0);
        check("reset tx_bit", 32'(tx[0]), 32'd1);
        check("reset tx_active", 32'(act[1]), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("release in_ready", 32'(ready[0]), 32'd1);
        check("release tx_bit", 32'(tx[0]), 32'd1);
        tick();

        // 2. single symbol at BIT_PERIOD=1
        w3 = '0;
        w3.c[0] = 6'h2A;
        w3.e[0] = 2'b00;
        send(1, w3);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            bits[i] = tx[1];
        end
        check("symbol bits", 32'(bits), 32'(11'b111_0101_0000));
        wait_idle();

        // 3. full word at BIT_PERIOD=4
        wa.c = {6'h15, 6'h00, 6'h3F, 6'h01};
        wa.e = {2'b11, 2'b10, 2'b01, 2'b00};
        send(0, wa);
        active_cnt = 0;
        done_at    = 0;
        done_seen  = 0;
        for (int n = 1; n <= 180; n++) begin
            @(negedge clk);
            if (act[0]) active_cnt++;
            if (done[0]) begin
                done_at = n;
                done_seen++;
            end
            if (n == 1 || n == 45 || n == 89 || n == 133)
                check($sformatf("chunk_idx at %0d", n), 32'(idx[0]), 32'((n - 1) / 44));
            if (n == 37 || n == 81 || n == 125 || n == 169)
                check($sformatf("parity at %0d", n), 32'(tx[0]), 32'd1);
        end
        check("active cycles", 32'(active_cnt), 32'd176);
        check("frame_done cycle", 32'(done_at), 32'd177);
        check("frame_done count", 32'(done_seen), 32'd1);
        tick();
        wait_idle();

        // 4. back-to-back with in_valid held high
        base  = low_runs.size();
        abase = after_done.size();
        wb.c  = {6'h2B, 6'h11, 6'h3C, 6'h07};
        wb.e  = {2'b01, 2'b11, 2'b00, 2'b10};
        w_in[0]  = wa;
        valid[0] = 1'b1;
        tick();
        w_in[0] = wb;
        repeat (177) tick();
        valid[0] = 1'b0;
        wait_idle();
        repeat (3) tick();
        if (low_runs.size() >= base + 2 && after_done.size() >= abase + 2) begin
            check("busy run 1", 32'(low_runs[base]), 32'd176);
            check("busy run 2", 32'(low_runs[base + 1]), 32'd176);
            check("gap start bit", 32'(after_done[abase]), 32'(2'b01));
            check("idle after 2nd", 32'(after_done[abase + 1]), 32'(2'b10));
        end else begin
            check("back-to-back observations", 32'(low_runs.size() - base), 32'd2);
        end

        // 5. reset during c2 data bits
        send(0, wb);
        repeat (59) tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        check("abort tx_bit", 32'(tx[0]), 32'd1);
        check("abort tx_active", 32'(act[0]), 32'd0);
        tick();
        reset = 1'b0;
        dbase = done_cnt;
        repeat (200) tick();
        check("no done after abort", 32'(done_cnt - dbase), 32'd0);
        send(0, wa);
        wait_idle();
        repeat (2) tick();
        check("done after restart", 32'(done_cnt - dbase), 32'd1);

        // 6. inputs wiggle during frames on both instances
        w_in[0]  = wb;
        w_in[1]  = wa;
        valid[0] = 1'b1;
        valid[1] = 1'b1;
        tick();
        valid[0] = 1'b0;
        valid[1] = 1'b0;
        for (int n = 0; n < 190; n++) begin
            w_in[0] = word_t'({$urandom, $urandom});
            w_in[1] = word_t'({$urandom, $urandom});
            tick();
        end
        wait_idle();
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
